// File: rtl/ram_pin_serdes.sv
// Read bridge from a request port to a narrow RAM pin interface. The address goes out LSB nibble
// first, then a programmable turnaround, then the read data is assembled LSB nibble first.
module ram_pin_serdes #(
  parameter int RAM_PINS  = 4,
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16,
  parameter int LAT_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LAT_BITS-1:0]  latency,
  input  logic                 sync_data,
  input  logic                 loopback,
  output logic [RAM_PINS-1:0]  addr_pins,
  input  logic [RAM_PINS-1:0]  data_pins,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy
);

  localparam int NA  = ADDR_BITS / RAM_PINS;
  localparam int ND  = DATA_BITS / RAM_PINS;
  localparam int CA  = (NA > 1) ? $clog2(NA) : 1;
  localparam int CD  = (ND > 1) ? $clog2(ND) : 1;
  localparam int CW0 = (CA > CD) ? CA : CD;
  localparam int CW  = (CW0 > LAT_BITS) ? CW0 : LAT_BITS;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [RAM_PINS-1:0]  addr_q;
  logic [LAT_BITS-1:0]  lat_q;
  logic [RAM_PINS-1:0]  d_q;
  logic [RAM_PINS-1:0]  d_s;
  logic [DATA_BITS-1:0] dat_sh;
  logic [DATA_BITS-1:0] d_next;
  logic                 first_sample;

  assign d_s       = sync_data ? d_q : data_pins;
  // New nibbles enter at the top so the first one received ends up as the LSB nibble.
  assign d_next    = (dat_sh >> RAM_PINS) | (DATA_BITS'(d_s) << (DATA_BITS - RAM_PINS));
  assign first_sample = (state == WAIT && cnt == '0) ||
                        (state == ADDR && cnt == '0 && lat_q == '0);
  assign req_ready = !reset && !loopback && (state == IDLE);
  assign addr_pins = loopback ? d_s : addr_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_sh  <= '0;
      addr_q   <= '0;
      lat_q    <= '0;
      d_q      <= '0;
      dat_sh   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      d_q      <= data_pins;
      rd_valid <= 1'b0;
      if (loopback) begin
        state  <= IDLE;
        addr_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              addr_q  <= req_addr[RAM_PINS-1:0];
              addr_sh <= req_addr >> RAM_PINS;
              lat_q   <= latency;
              cnt     <= CW'(NA - 1);
              state   <= ADDR;
            end
          end
          ADDR: begin
            if (cnt != '0) begin
              addr_q  <= addr_sh[RAM_PINS-1:0];
              addr_sh <= addr_sh >> RAM_PINS;
              cnt     <= cnt - CNT_ONE;
            end else begin
              addr_q <= '0;
              if (lat_q != '0) begin
                state <= WAIT;
                cnt   <= CW'(lat_q) - CNT_ONE;
              end
            end
          end
          WAIT: begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
          end
          DATA: begin
            if (cnt != '0) begin
              dat_sh <= d_next;
              cnt    <= cnt - CNT_ONE;
            end else begin
              rd_data  <= d_next;
              rd_valid <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // Nibble 0 lands on the edge that ends the turnaround, or the address phase if latency is 0.
        if (first_sample) begin
          if (ND == 1) begin
            rd_data  <= d_next;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            dat_sh <= d_next;
            cnt    <= CW'(ND - 2);
            state  <= DATA;
          end
        end
      end
    end
  end

endmodule
